// File: rtl/program_memory_loader_pkg.sv
// Shared definitions for the serial program-memory loader: command codes,
// frame sizes and FSM state encoding.
package program_memory_loader_pkg;

    localparam int CMD_BITS        = 6;
    localparam int DATA_FRAME_BITS = 16;

    localparam logic [CMD_BITS-1:0] CMD_LOAD_DATA  = 6'h02;
    localparam logic [CMD_BITS-1:0] CMD_INC_ADDR   = 6'h06;
    localparam logic [CMD_BITS-1:0] CMD_BEGIN_PROG = 6'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_PROG = 2'd3
    } state_t;

endpackage

// File: rtl/program_memory_loader_icsp_sync_edge.sv
// Brings the programmer's clock/data pair into the clk domain and flags one
// bit per falling edge of the synchronised serial clock.
module icsp_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic icsp_clk,
    input  logic icsp_data,
    output logic bit_valid,
    output logic bit_value
);

    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_s3  <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            clk_s1  <= icsp_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= icsp_data;
            data_s2 <= data_s1;
        end
    end

    // Data shares the clock's synchroniser depth, so it lines up with the edge.
    assign bit_valid = clk_s3 & ~clk_s2;
    assign bit_value = data_s2;

endmodule

// File: rtl/program_memory_loader.sv
// ICSP-style serial writer for the instruction store: decodes 6-bit commands
// and 16-bit data frames, and drives the program memory write port.
module program_memory_loader #(
    parameter int ADDR_WIDTH  = 13,
    parameter int INSTR_WIDTH = 14,
    parameter int PROG_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_en,
    input  logic                   icsp_clk,
    input  logic                   icsp_data,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   busy,
    output logic                   cpu_hold
);
    import program_memory_loader_pkg::*;

    localparam int PCW = $clog2(PROG_CYCLES + 1);

    state_t                 state;
    logic [INSTR_WIDTH-1:0] shift_sr;
    logic [3:0]             bit_cnt;
    logic                   cmd_pend;
    logic [PCW-1:0]         prog_cnt;
    logic                   bit_valid;
    logic                   bit_value;

    icsp_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .icsp_clk  (icsp_clk),
        .icsp_data (icsp_data),
        .bit_valid (bit_valid),
        .bit_value (bit_value)
    );

    // The shifter only keeps data bits 1..14: the start bit falls off the
    // bottom and the stop bit is never shifted in. Commands land in the top bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            shift_sr <= '0;
            bit_cnt  <= '0;
            cmd_pend <= 1'b0;
            prog_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
        end else begin
            cpu_hold <= prog_en;
            wr_en    <= 1'b0;
            if (!prog_en) begin
                state    <= ST_IDLE;
                shift_sr <= '0;
                bit_cnt  <= '0;
                cmd_pend <= 1'b0;
                prog_cnt <= '0;
                wr_addr  <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                    end
                    ST_CMD: begin
                        if (cmd_pend) begin
                            cmd_pend <= 1'b0;
                            case (shift_sr[INSTR_WIDTH-1 -: CMD_BITS])
                                CMD_LOAD_DATA: begin
                                    state   <= ST_DATA;
                                    bit_cnt <= '0;
                                end
                                CMD_INC_ADDR: wr_addr <= wr_addr + ADDR_WIDTH'(1);
                                CMD_BEGIN_PROG: begin
                                    wr_en    <= 1'b1;
                                    busy     <= 1'b1;
                                    prog_cnt <= PCW'(PROG_CYCLES);
                                    state    <= ST_PROG;
                                end
                                default: ;
                            endcase
                        end else if (bit_valid) begin
                            shift_sr <= {bit_value, shift_sr[INSTR_WIDTH-1:1]};
                            if (bit_cnt == 4'(CMD_BITS - 1)) begin
                                bit_cnt  <= '0;
                                cmd_pend <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (bit_valid) begin
                            if (bit_cnt == 4'(DATA_FRAME_BITS - 1)) begin
                                wr_data <= shift_sr;
                                bit_cnt <= '0;
                                state   <= ST_CMD;
                            end else begin
                                shift_sr <= {bit_value, shift_sr[INSTR_WIDTH-1:1]};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_PROG: begin
                        // Serial edges arriving here are dropped on purpose.
                        if (prog_cnt <= PCW'(1)) begin
                            busy     <= 1'b0;
                            prog_cnt <= '0;
                            state    <= ST_CMD;
                        end else begin
                            prog_cnt <= prog_cnt - PCW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
